fetch_stage: RTL and testbench

Instruction fetch stage of the LC-3 pipeline, directly upstream of decode. Owns the program counter, issues reads to the synchronous instruction memory, and buffers returned instructions with their next-PC in a small queue. Drives decode with a valid/ready handshake carrying `instr_dout` and `npc_out`. Handles branch redirects by flushing the queue and discarding the in-flight read.

---
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: LC-3 instruction fetch. Owns the PC, reads imem, and queues {instr, npc} for decode.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module fetch_stage #(
  parameter int                   INSTRUCTION_WIDTH = 16,
  parameter int                   NPC_WIDTH         = 16,
  parameter logic [NPC_WIDTH-1:0] RESET_PC          = 'h3000,
  parameter int                   DEPTH             = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable_fetch,
  input  logic                         br_taken,
  input  logic [NPC_WIDTH-1:0]         taddr,
  output logic                         imem_rd,
  output logic [NPC_WIDTH-1:0]         imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_dout,
  output logic [NPC_WIDTH-1:0]         pc,
  output logic                         instr_valid,
  output logic [INSTRUCTION_WIDTH-1:0] instr_dout,
  output logic [NPC_WIDTH-1:0]         npc_out,
  input  logic                         decode_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [INSTRUCTION_WIDTH-1:0] q_instr [DEPTH];
  logic [NPC_WIDTH-1:0]         q_npc   [DEPTH];
  logic [PW-1:0]                head;
  logic [PW-1:0]                tail;
  logic [CW-1:0]                count;
  logic                         inflight;
  logic [NPC_WIDTH-1:0]         inflight_npc;

  logic          pop;
  logic          wr;
  logic [CW:0]   occupancy;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign instr_valid = (count != '0);
  assign instr_dout  = q_instr[head];
  assign npc_out     = q_npc[head];
  assign imem_addr   = pc;

  // A redirect kills both the pop and the pending response in the same cycle.
  assign pop = instr_valid && decode_ready && !br_taken;
  assign wr  = inflight && !br_taken;

  // Slots promised = entries held + response pending, less the one leaving now.
  assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
  assign imem_rd   = !reset && enable_fetch && !br_taken && (occupancy < (CW + 1)'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc           <= RESET_PC;
      inflight     <= 1'b0;
      inflight_npc <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_npc[i]   <= '0;
      end
    end else if (br_taken) begin
      pc       <= taddr;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_rd;
      if (imem_rd) begin
        pc           <= pc + 1'b1;
        inflight_npc <= pc + 1'b1;
      end
      if (wr) begin
        q_instr[tail] <= imem_dout;
        q_npc[tail]   <= inflight_npc;
        tail          <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      count <= count + CW'(wr) - CW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    wr |-> (count < CW'(DEPTH)));

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, hand-written corner sequences, then random traffic vs a queue model.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_fetch = 1'b0;
  logic        br_taken = 1'b0;
  logic        decode_ready = 1'b0;
  logic [15:0] taddr = 16'h0;
  logic [15:0] imem_dout = 16'h0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic        instr_valid;
  logic [15:0] instr_dout;
  logic [15:0] npc_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [65536];

  fetch_stage #(
    .INSTRUCTION_WIDTH(16), .NPC_WIDTH(16), .RESET_PC(16'h3000), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .enable_fetch(enable_fetch), .br_taken(br_taken),
    .taddr(taddr), .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .pc(pc), .instr_valid(instr_valid), .instr_dout(instr_dout), .npc_out(npc_out),
    .decode_ready(decode_ready)
  );

  always #5 clock = ~clock;

  // Synchronous memory; garbage on idle cycles so a spurious enqueue shows up.
  always @(posedge clock) imem_dout <= imem_rd ? mem[imem_addr] : 16'($urandom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rb;
    bit          en;
    bit          br;
    bit          rdy;
    logic [15:0] taddr;
    bit          rd;
    logic [15:0] addr;
    bit          v;
    logic [15:0] dout;
    logic [15:0] npc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rb, int en, int br, int rdy, int ta,
                              int rd, int addr, int v, int dout, int npc);
    vec_t r;
    r.rb = rb[0]; r.en = en[0]; r.br = br[0]; r.rdy = rdy[0];
    r.taddr = ta[15:0]; r.rd = rd[0]; r.addr = addr[15:0];
    r.v = v[0]; r.dout = dout[15:0]; r.npc = npc[15:0];
    return r;
  endfunction

  typedef struct {
    logic [15:0] instr;
    logic [15:0] npc;
  } ent_t;

  ent_t        mq[$];
  bit          m_infl;
  logic [15:0] m_infl_a;
  logic [15:0] m_pc;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    mem[16'h3000] = 16'h1111; mem[16'h3001] = 16'h2222;
    mem[16'h3002] = 16'h3333; mem[16'h3003] = 16'h4444;
    mem[16'h4000] = 16'hABCD; mem[16'hFFFF] = 16'hBEEF;

    //            rb en br rdy taddr    rd addr    v dout     npc
    // streaming, then redirect+pop to FFFF (wrap)
    vecs.push_back(mk(1, 1, 0, 1, 'h0000, 1, 'h3000, 0, 'h0000, 'h0000));
    vecs.push_back(mk(0, 1, 0, 1, 'h0000, 1, 'h3001, 0, 'h0000, 'h0000));
    vecs.push_back(mk(0, 1, 0, 1, 'h0000, 1, 'h3002, 1, 'h1111, 'h3001));
    vecs.push_back(mk(0, 1, 0, 1, 'h0000, 1, 'h3003, 1, 'h2222, 'h3002));
    vecs.push_back(mk(0, 1, 0, 1, 'h0000, 1, 'h3004, 1, 'h3333, 'h3003));
    vecs.push_back(mk(0, 1, 1, 1, 'hFFFF, 0, 'h3005, 1, 'h4444, 'h3004));
    vecs.push_back(mk(0, 1, 0, 0, 'h0000, 1, 'hFFFF, 0, 'h0000, 'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 'h0000, 1, 'h0000, 0, 'h0000, 'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0001, 1, 'hBEEF, 'h0000));
    // backpressure, then release
    vecs.push_back(mk(1, 1, 0, 0, 'h0000, 1, 'h3000, 0, 'h0000, 'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 'h0000, 1, 'h3001, 0, 'h0000, 'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h3002, 1, 'h1111, 'h3001));
    vecs.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h3002, 1, 'h1111, 'h3001));
    vecs.push_back(mk(0, 1, 0, 1, 'h0000, 1, 'h3002, 1, 'h1111, 'h3001));
    vecs.push_back(mk(0, 1, 0, 1, 'h0000, 1, 'h3003, 1, 'h2222, 'h3002));
    vecs.push_back(mk(0, 1, 0, 1, 'h0000, 1, 'h3004, 1, 'h3333, 'h3003));
    // redirect with a read in flight, then redirect on a full queue, then fetch disabled
    vecs.push_back(mk(1, 1, 0, 0, 'h0000, 1, 'h3000, 0, 'h0000, 'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 'h0000, 1, 'h3001, 0, 'h0000, 'h0000));
    vecs.push_back(mk(0, 1, 1, 0, 'h4000, 0, 'h3002, 1, 'h1111, 'h3001));
    vecs.push_back(mk(0, 1, 0, 0, 'h0000, 1, 'h4000, 0, 'h0000, 'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 'h0000, 1, 'h4001, 0, 'h0000, 'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h4002, 1, 'hABCD, 'h4001));
    vecs.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h4002, 1, 'hABCD, 'h4001));
    vecs.push_back(mk(0, 1, 1, 1, 'h3000, 0, 'h4002, 1, 'hABCD, 'h4001));
    vecs.push_back(mk(0, 0, 0, 1, 'h0000, 0, 'h3000, 0, 'h0000, 'h0000));
    vecs.push_back(mk(0, 0, 0, 1, 'h0000, 0, 'h3000, 0, 'h0000, 'h0000));

    foreach (vecs[i]) begin
      @(negedge clock);
      if (vecs[i].rb) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
      enable_fetch = vecs[i].en;
      br_taken     = vecs[i].br;
      decode_ready = vecs[i].rdy;
      taddr        = vecs[i].taddr;
      #1;
      chk($sformatf("v%0d.imem_rd", i), 32'(imem_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d.imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d.pc", i), 32'(pc), 32'(vecs[i].addr));
      chk($sformatf("v%0d.instr_valid", i), 32'(instr_valid), 32'(vecs[i].v));
      if (vecs[i].v || vecs[i].rb) begin
        chk($sformatf("v%0d.instr_dout", i), 32'(instr_dout), 32'(vecs[i].dout));
        chk($sformatf("v%0d.npc_out", i), 32'(npc_out), 32'(vecs[i].npc));
      end
    end

    // Reset asserted mid-cycle while the queue holds data.
    @(negedge clock);
    br_taken = 1'b0; enable_fetch = 1'b1; decode_ready = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid.pre_valid", 32'(instr_valid), 32'd1);
    chk("mid.pre_dout", 32'(instr_dout), 32'h1111);
    #1;
    reset = 1'b1;
    #1;
    chk("mid.rst_valid", 32'(instr_valid), 32'd0);
    chk("mid.rst_dout", 32'(instr_dout), 32'h0);
    chk("mid.rst_npc", 32'(npc_out), 32'h0);
    chk("mid.rst_pc", 32'(pc), 32'h3000);
    chk("mid.rst_rd", 32'(imem_rd), 32'd0);
    reset = 1'b0;
    decode_ready = 1'b1;
    #1;
    chk("mid.post_rd", 32'(imem_rd), 32'd1);
    chk("mid.post_addr", 32'(imem_addr), 32'h3000);
    @(negedge clock);
    chk("mid.post_valid0", 32'(instr_valid), 32'd0);
    @(negedge clock);
    chk("mid.post_valid1", 32'(instr_valid), 32'd1);
    chk("mid.post_dout", 32'(instr_dout), 32'h1111);
    chk("mid.post_npc", 32'(npc_out), 32'h3001);

    // Random traffic against a queue-level model.
    @(negedge clock);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    mq.delete();
    m_infl = 1'b0;
    m_infl_a = 16'h0;
    m_pc = 16'h3000;
    for (int c = 0; c < 3000; c++) begin
      bit pop;
      bit exp_rd;
      if (c != 0) @(negedge clock);
      enable_fetch = ($urandom_range(0, 3) != 0);
      br_taken     = ($urandom_range(0, 15) == 0);
      decode_ready = ($urandom_range(0, 2) != 0);
      taddr        = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      #1;
      pop    = (mq.size() > 0) && decode_ready && !br_taken;
      exp_rd = enable_fetch && !br_taken &&
               ((mq.size() + int'(m_infl) - int'(pop)) < DEPTH);
      chk($sformatf("r%0d.imem_rd", c), 32'(imem_rd), 32'(exp_rd));
      chk($sformatf("r%0d.imem_addr", c), 32'(imem_addr), 32'(m_pc));
      chk($sformatf("r%0d.pc", c), 32'(pc), 32'(m_pc));
      chk($sformatf("r%0d.instr_valid", c), 32'(instr_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk($sformatf("r%0d.instr_dout", c), 32'(instr_dout), 32'(mq[0].instr));
        chk($sformatf("r%0d.npc_out", c), 32'(npc_out), 32'(mq[0].npc));
      end
      @(posedge clock);
      if (br_taken) begin
        mq.delete();
        m_infl = 1'b0;
        m_pc = taddr;
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_infl) mq.push_back('{mem[m_infl_a], 16'(m_infl_a + 16'd1)});
        m_infl = exp_rd;
        if (exp_rd) begin
          m_infl_a = m_pc;
          m_pc = m_pc + 16'd1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
